// File: rtl/rv_ctrl_pkg.sv
// Shared encodings between the multi-cycle control FSM and the RV32I datapath.
// State codes double as the debug state_o value.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_ALU  = 4'd2,
    S_WB_ALU    = 4'd3,
    S_EXEC_ADDR = 4'd4,
    S_MEM_RD    = 4'd5,
    S_WB_MEM    = 4'd6,
    S_MEM_WR    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JAL       = 4'd9,
    S_TRAP      = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_R,
    CLS_I,
    CLS_BR
  } alu_cls_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] ASEL_PC    = 2'd0;
  localparam logic [1:0] ASEL_OLDPC = 2'd1;
  localparam logic [1:0] ASEL_RS1   = 2'd2;

  localparam logic [1:0] BSEL_RS2  = 2'd0;
  localparam logic [1:0] BSEL_IMM  = 2'd1;
  localparam logic [1:0] BSEL_FOUR = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU operation decode from instruction class, funct3 and IR[30].
// Purely combinational, no handshake.
module alu_dec
  import rv_ctrl_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (cls_i)
      CLS_R, CLS_I: begin
        case (funct3_i)
          3'b000:  alu_ctrl_o = (cls_i == CLS_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  alu_ctrl_o = ALU_SLTU;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = funct7_5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      CLS_BR: begin
        // Equality compares subtract; signed/unsigned orderings use the set-less-than ops.
        case (funct3_i[2:1])
          2'b00:   alu_ctrl_o = ALU_SUB;
          2'b10:   alu_ctrl_o = ALU_SLT;
          2'b11:   alu_ctrl_o = ALU_SLTU;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback strobes.
// Memory states hold mem_req until mem_ready; a stalled bus traps after MEM_TIMEOUT cycles.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [3:0] alu_ctrl,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state_o
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;
  logic       req_st, wait_miss, timeout, br_taken, br_legal;
  alu_cls_e   cls_c;

  assign req_st    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign wait_miss = req_st && !mem_ready;
  // The limit is checked on the last permitted wait cycle so a late ready still completes.
  assign timeout   = wait_miss && (timer_q == TMO_LAST);
  assign br_legal  = (funct3[2:1] != 2'b01);

  always_comb begin
    case (funct3)
      3'b000, 3'b101, 3'b111: br_taken = alu_zero;
      3'b001, 3'b100, 3'b110: br_taken = !alu_zero;
      default:                br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          state_d = (state_q == S_FETCH)  ? S_DECODE :
                    (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end else if (timeout) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OPC_OP, OPC_OPIMM:   state_d = S_EXEC_ALU;
          OPC_LOAD, OPC_STORE: state_d = S_EXEC_ADDR;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_JAL:             state_d = S_JAL;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_ALU:  state_d = S_WB_ALU;
      S_EXEC_ADDR: state_d = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
      S_BRANCH: begin
        state_d = br_legal ? S_FETCH : S_TRAP;
        if (!br_legal) illegal_d = 1'b1;
      end
      S_WB_ALU, S_WB_MEM, S_JAL: state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    if (state_d != state_q) timer_d = 8'd0;
    else if (wait_miss)     timer_d = timer_q + 8'd1;
    else                    timer_d = timer_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      timer_q   <= 8'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Outputs are forced idle while rst is sampled so no write can slip out with reset.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALUOUT;
    alu_a_sel = ASEL_PC;
    alu_b_sel = BSEL_RS2;
    cls_c     = CLS_ADD;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_b_sel = BSEL_FOUR;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
        end
        S_DECODE: begin
          alu_a_sel = ASEL_OLDPC;
          alu_b_sel = BSEL_IMM;
        end
        S_EXEC_ALU: begin
          alu_a_sel = ASEL_RS1;
          alu_b_sel = (opcode == OPC_OP) ? BSEL_RS2 : BSEL_IMM;
          cls_c     = (opcode == OPC_OP) ? CLS_R : CLS_I;
        end
        S_WB_ALU: rf_we = 1'b1;
        S_EXEC_ADDR: begin
          alu_a_sel = ASEL_RS1;
          alu_b_sel = BSEL_IMM;
        end
        S_MEM_RD: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
        end
        S_WB_MEM: begin
          rf_we  = 1'b1;
          wb_sel = WB_MDR;
        end
        S_MEM_WR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
        end
        S_BRANCH: begin
          alu_a_sel = ASEL_RS1;
          cls_c     = CLS_BR;
          pc_we     = br_legal && br_taken;
          pc_sel    = 1'b1;
        end
        S_JAL: begin
          rf_we  = 1'b1;
          wb_sel = WB_PC;
          pc_we  = 1'b1;
          pc_sel = 1'b1;
        end
        default: ;
      endcase
    end
  end

  alu_dec u_alu_dec (
    .cls_i      (cls_c),
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .alu_ctrl_o (alu_ctrl)
  );

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle stimulus and expected outputs queued together, compared on the falling edge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst, funct7_5, alu_zero, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we, illegal, bus_err;
  logic [1:0] wb_sel, alu_a_sel, alu_b_sel;
  logic [3:0] alu_ctrl, state_o;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .bus_err(bus_err), .state_o(state_o)
  );

  // sb = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we}
  typedef struct packed {
    logic [3:0] st; logic [6:0] sb; logic [1:0] wb; logic [1:0] a; logic [1:0] b;
    logic [3:0] alu; logic ill; logic be;
  } out_t;
  typedef struct packed {
    logic r; logic [6:0] opc; logic [2:0] f3; logic f7; logic z; logic rdy;
  } stim_t;
  typedef struct packed { logic r; logic [2:0] f3; logic f7; logic [3:0] alu; } av_t;
  typedef struct packed { logic [2:0] f3; logic z; logic [3:0] alu; logic tk; } bv_t;

  localparam logic [6:0] SB_NONE = 7'b0000000, SB_FW = 7'b1000000, SB_FG = 7'b1001100;
  localparam logic [6:0] SB_RD = 7'b1010000, SB_WR = 7'b1110000, SB_WB = 7'b0000001;
  localparam logic [6:0] SB_BRT = 7'b0000110, SB_BRN = 7'b0000010, SB_JAL = 7'b0000111;
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011, STR = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, LUI = 7'b0110111;

  stim_t stim_q[$];
  out_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic out_t ex(input logic [3:0] st, input logic [6:0] sb, input logic [1:0] wb,
                              input logic [1:0] a, input logic [1:0] b, input logic [3:0] alu,
                              input logic ill, input logic be);
    return {st, sb, wb, a, b, alu, ill, be};
  endfunction

  function automatic out_t observe();
    return {state_o, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, rf_we,
            wb_sel, alu_a_sel, alu_b_sel, alu_ctrl, illegal, bus_err};
  endfunction

  task automatic pv(input logic r, input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                    input logic z, input logic rdy, input out_t e);
    stim_q.push_back({r, opc, f3, f7, z, rdy});
    exp_q.push_back(e);
  endtask

  task automatic step(input stim_t s);
    @(negedge clk);
    rst = s.r; opcode = s.opc; funct3 = s.f3; funct7_5 = s.f7; alu_zero = s.z; mem_ready = s.rdy;
    #1;
  endtask

  task automatic test_reset();
    stim_t s; out_t e; int n = 0;
    pv(1'b1, OP, 3'd0, 1'b0, 1'b0, 1'b0, ex(4'd0, SB_NONE, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    pv(1'b1, OP, 3'd0, 1'b0, 1'b0, 1'b1, ex(4'd0, SB_NONE, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); step(s); vectors++;
      if (observe() !== e) begin
        miscompares++; $display("FAIL reset vec%0d: got %b want %b", n, observe(), e);
      end
      n++;
    end
  endtask

  task automatic test_alu();
    av_t tbl[11]; logic [6:0] opc; logic [1:0] b; stim_t s; out_t e; int n = 0;
    tbl = '{'{1'b1, 3'b000, 1'b0, 4'd0}, '{1'b1, 3'b000, 1'b1, 4'd1}, '{1'b0, 3'b000, 1'b1, 4'd0},
            '{1'b1, 3'b001, 1'b0, 4'd5}, '{1'b0, 3'b010, 1'b0, 4'd8}, '{1'b1, 3'b011, 1'b0, 4'd9},
            '{1'b0, 3'b100, 1'b0, 4'd4}, '{1'b1, 3'b101, 1'b0, 4'd6}, '{1'b0, 3'b101, 1'b1, 4'd7},
            '{1'b1, 3'b110, 1'b0, 4'd3}, '{1'b0, 3'b111, 1'b0, 4'd2}};
    foreach (tbl[i]) begin
      opc = tbl[i].r ? OP : OPI;
      b   = tbl[i].r ? 2'd0 : 2'd1;
      pv(1'b0, opc, tbl[i].f3, tbl[i].f7, 1'b0, 1'b1, ex(4'd0, SB_FG, 2'd0, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0));
      pv(1'b0, opc, tbl[i].f3, tbl[i].f7, 1'b0, 1'b0, ex(4'd1, SB_NONE, 2'd0, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0));
      pv(1'b0, opc, tbl[i].f3, tbl[i].f7, 1'b0, 1'b0, ex(4'd2, SB_NONE, 2'd0, 2'd2, b, tbl[i].alu, 1'b0, 1'b0));
      pv(1'b0, opc, tbl[i].f3, tbl[i].f7, 1'b0, 1'b0, ex(4'd3, SB_WB, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    end
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); step(s); vectors++;
      if (observe() !== e) begin
        miscompares++; $display("FAIL alu vec%0d: got %b want %b", n, observe(), e);
      end
      n++;
    end
  endtask

  task automatic test_branch();
    bv_t tbl[6]; stim_t s; out_t e; int n = 0;
    tbl = '{'{3'b001, 1'b0, 4'd1, 1'b1}, '{3'b000, 1'b0, 4'd1, 1'b0}, '{3'b100, 1'b0, 4'd8, 1'b1},
            '{3'b111, 1'b0, 4'd9, 1'b0}, '{3'b000, 1'b1, 4'd1, 1'b1}, '{3'b101, 1'b1, 4'd8, 1'b1}};
    foreach (tbl[i]) begin
      pv(1'b0, BR, tbl[i].f3, 1'b0, tbl[i].z, 1'b1, ex(4'd0, SB_FG, 2'd0, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0));
      pv(1'b0, BR, tbl[i].f3, 1'b0, tbl[i].z, 1'b0, ex(4'd1, SB_NONE, 2'd0, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0));
      pv(1'b0, BR, tbl[i].f3, 1'b0, tbl[i].z, 1'b0,
         ex(4'd8, tbl[i].tk ? SB_BRT : SB_BRN, 2'd0, 2'd2, 2'd0, tbl[i].alu, 1'b0, 1'b0));
    end
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); step(s); vectors++;
      if (observe() !== e) begin
        miscompares++; $display("FAIL branch vec%0d: got %b want %b", n, observe(), e);
      end
      n++;
    end
  endtask

  task automatic test_jal();
    stim_t s; out_t e; int n = 0;
    pv(1'b0, JL, 3'd0, 1'b0, 1'b0, 1'b1, ex(4'd0, SB_FG, 2'd0, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0));
    pv(1'b0, JL, 3'd0, 1'b0, 1'b0, 1'b0, ex(4'd1, SB_NONE, 2'd0, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0));
    pv(1'b0, JL, 3'd0, 1'b0, 1'b0, 1'b0, ex(4'd9, SB_JAL, 2'd2, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); step(s); vectors++;
      if (observe() !== e) begin
        miscompares++; $display("FAIL jal vec%0d: got %b want %b", n, observe(), e);
      end
      n++;
    end
  endtask

  // Ready arrives on the last permitted wait cycle: the fetch must complete normally.
  task automatic test_ready_at_limit();
    stim_t s; out_t e; int n = 0;
    repeat (3) pv(1'b0, OPI, 3'd0, 1'b0, 1'b0, 1'b0, ex(4'd0, SB_FW, 2'd0, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0));
    pv(1'b0, OPI, 3'd0, 1'b0, 1'b0, 1'b1, ex(4'd0, SB_FG, 2'd0, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0));
    pv(1'b0, OPI, 3'd0, 1'b0, 1'b0, 1'b0, ex(4'd1, SB_NONE, 2'd0, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0));
    pv(1'b0, OPI, 3'd0, 1'b0, 1'b0, 1'b0, ex(4'd2, SB_NONE, 2'd0, 2'd2, 2'd1, 4'd0, 1'b0, 1'b0));
    pv(1'b0, OPI, 3'd0, 1'b0, 1'b0, 1'b0, ex(4'd3, SB_WB, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); step(s); vectors++;
      if (observe() !== e) begin
        miscompares++; $display("FAIL ready_at_limit vec%0d: got %b want %b", n, observe(), e);
      end
      n++;
    end
  endtask

  task automatic test_load();
    stim_t s; out_t e; int n = 0; int rd_req = 0;
    pv(1'b0, LD, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd0, SB_FW, 2'd0, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0));
    pv(1'b0, LD, 3'b010, 1'b0, 1'b0, 1'b1, ex(4'd0, SB_FG, 2'd0, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0));
    pv(1'b0, LD, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd1, SB_NONE, 2'd0, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0));
    pv(1'b0, LD, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd4, SB_NONE, 2'd0, 2'd2, 2'd1, 4'd0, 1'b0, 1'b0));
    repeat (3) pv(1'b0, LD, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd5, SB_RD, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    pv(1'b0, LD, 3'b010, 1'b0, 1'b0, 1'b1, ex(4'd5, SB_RD, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    pv(1'b0, LD, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd6, SB_WB, 2'd1, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); step(s); vectors++;
      if (mem_req && state_o == 4'd5) rd_req++;
      if (observe() !== e) begin
        miscompares++; $display("FAIL load vec%0d: got %b want %b", n, observe(), e);
      end
      n++;
    end
    vectors++;
    if (rd_req != 4) begin
      miscompares++; $display("FAIL load_req_cycles: got %0d want 4", rd_req);
    end
  endtask

  task automatic test_illegal();
    stim_t s; out_t e; int n = 0;
    pv(1'b0, LUI, 3'd0, 1'b0, 1'b0, 1'b1, ex(4'd0, SB_FG, 2'd0, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0));
    pv(1'b0, LUI, 3'd0, 1'b0, 1'b0, 1'b0, ex(4'd1, SB_NONE, 2'd0, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0));
    repeat (3) pv(1'b0, LUI, 3'd0, 1'b0, 1'b0, 1'b1, ex(4'd10, SB_NONE, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0));
    pv(1'b1, LUI, 3'd0, 1'b0, 1'b0, 1'b1, ex(4'd10, SB_NONE, 2'd0, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0));
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); step(s); vectors++;
      if (observe() !== e) begin
        miscompares++; $display("FAIL illegal vec%0d: got %b want %b", n, observe(), e);
      end
      n++;
    end
  endtask

  task automatic test_timeout();
    stim_t s; out_t e; int n = 0;
    repeat (4) pv(1'b0, OPI, 3'd0, 1'b0, 1'b0, 1'b0, ex(4'd0, SB_FW, 2'd0, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0));
    repeat (2) pv(1'b0, OPI, 3'd0, 1'b0, 1'b0, 1'b1, ex(4'd10, SB_NONE, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b1));
    pv(1'b1, OPI, 3'd0, 1'b0, 1'b0, 1'b0, ex(4'd10, SB_NONE, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b1));
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); step(s); vectors++;
      if (observe() !== e) begin
        miscompares++; $display("FAIL timeout vec%0d: got %b want %b", n, observe(), e);
      end
      n++;
    end
  endtask

  task automatic test_store_reset();
    stim_t s; out_t e; int n = 0;
    pv(1'b0, STR, 3'b010, 1'b0, 1'b0, 1'b1, ex(4'd0, SB_FG, 2'd0, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0));
    pv(1'b0, STR, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd1, SB_NONE, 2'd0, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0));
    pv(1'b0, STR, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd4, SB_NONE, 2'd0, 2'd2, 2'd1, 4'd0, 1'b0, 1'b0));
    pv(1'b0, STR, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd7, SB_WR, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    pv(1'b1, STR, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd7, SB_NONE, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    pv(1'b0, STR, 3'b010, 1'b0, 1'b0, 1'b1, ex(4'd0, SB_FG, 2'd0, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0));
    pv(1'b0, STR, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd1, SB_NONE, 2'd0, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0));
    pv(1'b0, STR, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd4, SB_NONE, 2'd0, 2'd2, 2'd1, 4'd0, 1'b0, 1'b0));
    pv(1'b0, STR, 3'b010, 1'b0, 1'b0, 1'b1, ex(4'd7, SB_WR, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0));
    pv(1'b0, STR, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd0, SB_FW, 2'd0, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0));
    while (exp_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front(); step(s); vectors++;
      if (observe() !== e) begin
        miscompares++; $display("FAIL store_reset vec%0d: got %b want %b", n, observe(), e);
      end
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; alu_zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_alu();
    test_branch();
    test_jal();
    test_ready_at_limit();
    test_load();
    test_illegal();
    test_timeout();
    test_store_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
